// File: rtl/alu_ctrl_pkg.sv
// Shared types for the shared-ALU controller: FSM state encoding, ALU_FUN group codes
// and the unit-enable bit positions with the group-to-enable decode.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] FUN_ARITH = 2'b00;
  localparam logic [1:0] FUN_LOGIC = 2'b01;
  localparam logic [1:0] FUN_CMP   = 2'b10;
  localparam logic [1:0] FUN_SHIFT = 2'b11;

  localparam int EN_ARITH = 0;
  localparam int EN_LOGIC = 1;
  localparam int EN_CMP   = 2;
  localparam int EN_SHIFT = 3;

  // fun[3:2] selects exactly one unit; the result is always one-hot.
  function automatic logic [3:0] fun_to_enable(input logic [3:0] fun);
    logic [3:0] en;
    en = '0;
    case (fun[3:2])
      FUN_ARITH: en[EN_ARITH] = 1'b1;
      FUN_LOGIC: en[EN_LOGIC] = 1'b1;
      FUN_CMP:   en[EN_CMP]   = 1'b1;
      FUN_SHIFT: en[EN_SHIFT] = 1'b1;
      default:   en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way grant logic for the shared ALU. ALU_RR_ARB_EN selects round-robin on
// contention (favour the requester that did not win last); otherwise req0 has fixed priority.
module alu_rr_arbiter (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

`ifdef ALU_RR_ARB_EN
  always_comb begin
    gnt_o = 2'b00;
    if (valid0_i && valid1_i) begin
      gnt_o = last_grant_i ? 2'b01 : 2'b10;
    end else if (valid0_i) begin
      gnt_o = 2'b01;
    end else if (valid1_i) begin
      gnt_o = 2'b10;
    end
  end
`else
  // History is irrelevant under fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    gnt_o = 2'b00;
    if (valid0_i) begin
      gnt_o = 2'b01;
    end else if (valid1_i) begin
      gnt_o = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one registered-output ALU between two requesters: IDLE->EXEC->CAPT->RESP, one op in flight.
// Contention policy set by ALU_RR_ARB_EN (round-robin when defined, req0 fixed priority otherwise).
module alu_arbiter_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             rest,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_fun,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_fun,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fun,
  output logic             arith_enable,
  output logic             logic_enable,
  output logic             cmp_enable,
  output logic             shift_enable,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // reqN_ready is combinational and only asserted in IDLE; rsp_* hold steady until rsp_ready.

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         fun_q, fun_d;
  logic [3:0]         en_q, en_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               last_grant_q, last_grant_d;

  logic [1:0]         gnt;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [3:0]         sel_fun;

  alu_rr_arbiter u_arb (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign sel_a   = gnt[1] ? req1_a   : req0_a;
  assign sel_b   = gnt[1] ? req1_b   : req0_b;
  assign sel_fun = gnt[1] ? req1_fun : req0_fun;

  assign req0_ready = (state_q == ST_IDLE) && gnt[0];
  assign req1_ready = (state_q == ST_IDLE) && gnt[1];

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    fun_d        = fun_q;
    en_d         = en_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          a_d          = sel_a;
          b_d          = sel_b;
          fun_d        = sel_fun;
          en_d         = fun_to_enable(sel_fun);
          rsp_id_d     = gnt[1];
          last_grant_d = gnt[1];
          state_d      = ST_EXEC;
        end
      end
      // The selected unit registers its result on the edge that leaves EXEC.
      ST_EXEC: begin
        en_d    = '0;
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        rsp_data_d  = alu_result;
        rsp_err_d   = ~alu_flag;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        en_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rest) begin
    if (!rest) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      fun_q        <= '0;
      en_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      fun_q        <= fun_d;
      en_q         <= en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_fun      = fun_q;
  assign arith_enable = en_q[EN_ARITH];
  assign logic_enable = en_q[EN_LOGIC];
  assign cmp_enable   = en_q[EN_CMP];
  assign shift_enable = en_q[EN_SHIFT];
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign dbg_state    = state_q;

endmodule
